// File: rtl/alu_reservation_station_if.sv
// ---------------------------------------------------------------------------
// alu_reservation_station_if
//   Bundles the dispatch, result-broadcast and issue signals of the ALU
//   reservation station.
//   slave  : the reservation station (consumes in_*, drives out_*)
//   master : the surroundings (rename/dispatch, func_units, flush source)
//   Signals:
//     in_flush                                  mispredict flush
//     in_disp_*  / out_disp_ready               dispatch request + back-pressure
//     in_fu_*                                   FU result broadcast (also writes ROB)
//     in_alu_ready / out_alu_*                  issue handshake to the ALU
// ---------------------------------------------------------------------------
interface alu_reservation_station_if #(
  parameter int GPR_SIZE     = 64,
  parameter int ROB_IDX_SIZE = 5,
  parameter int OP_SIZE      = 4
);
  logic                    in_flush;

  logic                    in_disp_valid;
  logic [OP_SIZE-1:0]      in_disp_op;
  logic                    in_disp_a_ready;
  logic [GPR_SIZE-1:0]     in_disp_val_a;
  logic [ROB_IDX_SIZE-1:0] in_disp_a_rob_index;
  logic                    in_disp_b_ready;
  logic [GPR_SIZE-1:0]     in_disp_val_b;
  logic [ROB_IDX_SIZE-1:0] in_disp_b_rob_index;
  logic                    in_disp_nzcv_ready;
  logic [3:0]              in_disp_nzcv;
  logic [ROB_IDX_SIZE-1:0] in_disp_nzcv_rob_index;
  logic                    in_disp_set_nzcv;
  logic [ROB_IDX_SIZE-1:0] in_disp_dst_rob_index;
  logic                    out_disp_ready;

  logic                    in_fu_done;
  logic [ROB_IDX_SIZE-1:0] in_fu_dst_rob_index;
  logic [GPR_SIZE-1:0]     in_fu_value;
  logic                    in_fu_set_nzcv;
  logic [3:0]              in_fu_nzcv;

  logic                    in_alu_ready;
  logic                    out_alu_start;
  logic [OP_SIZE-1:0]      out_alu_op;
  logic [GPR_SIZE-1:0]     out_alu_val_a;
  logic [GPR_SIZE-1:0]     out_alu_val_b;
  logic [ROB_IDX_SIZE-1:0] out_alu_dst_rob_index;
  logic                    out_alu_set_nzcv;
  logic [3:0]              out_alu_nzcv;

  modport slave (
    input  in_flush,
    input  in_disp_valid, in_disp_op,
    input  in_disp_a_ready, in_disp_val_a, in_disp_a_rob_index,
    input  in_disp_b_ready, in_disp_val_b, in_disp_b_rob_index,
    input  in_disp_nzcv_ready, in_disp_nzcv, in_disp_nzcv_rob_index,
    input  in_disp_set_nzcv, in_disp_dst_rob_index,
    output out_disp_ready,
    input  in_fu_done, in_fu_dst_rob_index, in_fu_value, in_fu_set_nzcv, in_fu_nzcv,
    input  in_alu_ready,
    output out_alu_start, out_alu_op, out_alu_val_a, out_alu_val_b,
    output out_alu_dst_rob_index, out_alu_set_nzcv, out_alu_nzcv
  );

  modport master (
    output in_flush,
    output in_disp_valid, in_disp_op,
    output in_disp_a_ready, in_disp_val_a, in_disp_a_rob_index,
    output in_disp_b_ready, in_disp_val_b, in_disp_b_rob_index,
    output in_disp_nzcv_ready, in_disp_nzcv, in_disp_nzcv_rob_index,
    output in_disp_set_nzcv, in_disp_dst_rob_index,
    input  out_disp_ready,
    output in_fu_done, in_fu_dst_rob_index, in_fu_value, in_fu_set_nzcv, in_fu_nzcv,
    output in_alu_ready,
    input  out_alu_start, out_alu_op, out_alu_val_a, out_alu_val_b,
    input  out_alu_dst_rob_index, out_alu_set_nzcv, out_alu_nzcv
  );
endinterface

// File: rtl/alu_reservation_station.sv
// ---------------------------------------------------------------------------
// alu_reservation_station
//   Holds dispatched ALU ops until both operands and NZCV are available, then
//   issues the oldest ready op to the ALU. Source values are captured from the
//   FU result broadcast. Entries form a collapsing queue: index 0 is oldest,
//   and an issued entry is squeezed out by shifting younger entries down.
//   Ports:
//     in_clk    rising-edge clock
//     in_rst_n  asynchronous active-low reset
//     bus       alu_reservation_station_if.slave (dispatch, broadcast, issue)
//   Widths must match the parameters of the connected interface.
// ---------------------------------------------------------------------------
module alu_reservation_station #(
  parameter int RS_SIZE      = 4,
  parameter int GPR_SIZE     = 64,
  parameter int ROB_IDX_SIZE = 5,
  parameter int OP_SIZE      = 4
) (
  input  logic                     in_clk,
  input  logic                     in_rst_n,
  alu_reservation_station_if.slave bus
);

  localparam int CNT_W = $clog2(RS_SIZE + 1);
  localparam int SEL_W = $clog2(RS_SIZE);

  typedef struct packed {
    logic                    valid;
    logic [OP_SIZE-1:0]      op;
    logic                    a_rdy;
    logic [GPR_SIZE-1:0]     a_val;
    logic [ROB_IDX_SIZE-1:0] a_tag;
    logic                    b_rdy;
    logic [GPR_SIZE-1:0]     b_val;
    logic [ROB_IDX_SIZE-1:0] b_tag;
    logic                    f_rdy;
    logic [3:0]              nzcv;
    logic [ROB_IDX_SIZE-1:0] f_tag;
    logic                    set_nzcv;
    logic [ROB_IDX_SIZE-1:0] dst;
  } entry_t;

  entry_t           ent_q [RS_SIZE];
  entry_t           ent_d [RS_SIZE];
  logic [CNT_W-1:0] count_q, count_d;

  // Capture a matching broadcast into any not-yet-ready source of one entry.
  // NZCV only wakes when the broadcast actually carries flags.
  function automatic entry_t wake(input entry_t                  e,
                                  input logic                    hit,
                                  input logic [ROB_IDX_SIZE-1:0] tag,
                                  input logic [GPR_SIZE-1:0]     val,
                                  input logic                    set_f,
                                  input logic [3:0]              f);
    entry_t r;
    r = e;
    if (hit && e.valid) begin
      if (!e.a_rdy && (e.a_tag == tag)) begin
        r.a_rdy = 1'b1;
        r.a_val = val;
      end
      if (!e.b_rdy && (e.b_tag == tag)) begin
        r.b_rdy = 1'b1;
        r.b_val = val;
      end
      if (set_f && !e.f_rdy && (e.f_tag == tag)) begin
        r.f_rdy = 1'b1;
        r.nzcv  = f;
      end
    end
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Issue selection: from registered state only, so a wakeup at edge t can
  // issue no earlier than cycle t+1.
  // -------------------------------------------------------------------------
  logic [RS_SIZE-1:0] ent_rdy;
  logic               any_rdy;
  logic [SEL_W-1:0]   sel;
  logic               issue;
  logic               disp_ready;
  entry_t             sel_e;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_rdy[i] = ent_q[i].valid & ent_q[i].a_rdy & ent_q[i].b_rdy & ent_q[i].f_rdy;
    end
  end

  // NOTE: every variable written in always_comb gets a default before any
  // conditional assignment, otherwise a latch is inferred.
  always_comb begin
    any_rdy = 1'b0;
    sel     = '0;
    // Walk from youngest to oldest so the last hit is the oldest ready entry.
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ent_rdy[i]) begin
        any_rdy = 1'b1;
        sel     = SEL_W'(i);
      end
    end
  end

  assign sel_e      = ent_q[sel];
  assign issue      = bus.in_alu_ready & ~bus.in_flush & any_rdy;
  assign disp_ready = (count_q < CNT_W'(RS_SIZE));

  assign bus.out_disp_ready        = disp_ready;
  assign bus.out_alu_start         = issue;
  assign bus.out_alu_op            = issue ? sel_e.op       : '0;
  assign bus.out_alu_val_a         = issue ? sel_e.a_val    : '0;
  assign bus.out_alu_val_b         = issue ? sel_e.b_val    : '0;
  assign bus.out_alu_dst_rob_index = issue ? sel_e.dst      : '0;
  assign bus.out_alu_set_nzcv      = issue ? sel_e.set_nzcv : 1'b0;
  assign bus.out_alu_nzcv          = issue ? sel_e.nzcv     : '0;

  // -------------------------------------------------------------------------
  // Next state: wakeup, collapse after issue, dispatch append, flush.
  // -------------------------------------------------------------------------
  logic             fu_hit;
  logic             disp_acc;
  logic [CNT_W-1:0] wr_idx;
  entry_t           disp_e;
  entry_t           disp_w;
  entry_t           woke [RS_SIZE+1];

  assign fu_hit   = bus.in_fu_done & ~bus.in_flush;
  assign disp_acc = bus.in_disp_valid & disp_ready & ~bus.in_flush;
  // The new entry lands just above the surviving ones; if one issues this
  // cycle the queue shrinks by one first.
  assign wr_idx   = count_q - CNT_W'(issue);

  always_comb begin
    disp_e          = '0;
    disp_e.valid    = 1'b1;
    disp_e.op       = bus.in_disp_op;
    disp_e.a_rdy    = bus.in_disp_a_ready;
    disp_e.a_val    = bus.in_disp_a_ready ? bus.in_disp_val_a : '0;
    disp_e.a_tag    = bus.in_disp_a_rob_index;
    disp_e.b_rdy    = bus.in_disp_b_ready;
    disp_e.b_val    = bus.in_disp_b_ready ? bus.in_disp_val_b : '0;
    disp_e.b_tag    = bus.in_disp_b_rob_index;
    disp_e.f_rdy    = bus.in_disp_nzcv_ready;
    disp_e.nzcv     = bus.in_disp_nzcv_ready ? bus.in_disp_nzcv : '0;
    disp_e.f_tag    = bus.in_disp_nzcv_rob_index;
    disp_e.set_nzcv = bus.in_disp_set_nzcv;
    disp_e.dst      = bus.in_disp_dst_rob_index;

    // The entry being dispatched also sees this cycle's broadcast, otherwise
    // a producer finishing exactly now would never be observed.
    disp_w = wake(disp_e, fu_hit, bus.in_fu_dst_rob_index, bus.in_fu_value,
                  bus.in_fu_set_nzcv, bus.in_fu_nzcv);

    for (int i = 0; i < RS_SIZE; i++) begin
      woke[i] = wake(ent_q[i], fu_hit, bus.in_fu_dst_rob_index, bus.in_fu_value,
                     bus.in_fu_set_nzcv, bus.in_fu_nzcv);
    end
    // Virtual empty slot above the top so the top entry clears on a shift.
    woke[RS_SIZE] = '0;

    for (int i = 0; i < RS_SIZE; i++) begin
      // Wakeup happens before the shift, so captured values move with their entry.
      ent_d[i] = (issue && (i >= int'(sel))) ? woke[i+1] : woke[i];
      if (disp_acc && (wr_idx == CNT_W'(i))) begin
        ent_d[i] = disp_w;
      end
    end

    count_d = count_q + CNT_W'(disp_acc) - CNT_W'(issue);

    if (bus.in_flush) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_d[i] = '0;
      end
      count_d = '0;
    end
  end

  // NOTE: the entry array is reset along with the count: the valid bits live
  // inside each entry and must be cleared for the queue to start empty.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      count_q <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge value of every other register.
      count_q <= count_d;
      for (int i = 0; i < RS_SIZE; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
module tb_alu_reservation_station;
  localparam int RS_SIZE = 4;
  localparam int GPR     = 64;
  localparam int RW      = 5;
  localparam int OW      = 4;
  localparam logic [3:0] OP_PLUS = 4'd1;
  localparam logic [3:0] OP_CSEL = 4'd7;

  logic in_clk   = 1'b0;
  logic in_rst_n = 1'b0;
  always #5 in_clk = ~in_clk;

  alu_reservation_station_if #(.GPR_SIZE(GPR), .ROB_IDX_SIZE(RW), .OP_SIZE(OW)) bus_if ();

  alu_reservation_station #(.RS_SIZE(RS_SIZE), .GPR_SIZE(GPR), .ROB_IDX_SIZE(RW), .OP_SIZE(OW)) dut (
    .in_clk   (in_clk),
    .in_rst_n (in_rst_n),
    .bus      (bus_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model: ordered list of waiting ops ----------------
  typedef struct {
    logic [3:0]  op;
    bit          a_rdy; logic [63:0] a; logic [4:0] a_tag;
    bit          b_rdy; logic [63:0] b; logic [4:0] b_tag;
    bit          f_rdy; logic [3:0]  f; logic [4:0] f_tag;
    bit          setf;
    logic [4:0]  dst;
  } m_ent_t;

  m_ent_t mq[$];

  function automatic m_ent_t m_wake(input m_ent_t e);
    if (bus_if.in_fu_done) begin
      if (!e.a_rdy && e.a_tag == bus_if.in_fu_dst_rob_index) begin e.a_rdy = 1; e.a = bus_if.in_fu_value; end
      if (!e.b_rdy && e.b_tag == bus_if.in_fu_dst_rob_index) begin e.b_rdy = 1; e.b = bus_if.in_fu_value; end
      if (bus_if.in_fu_set_nzcv && !e.f_rdy && e.f_tag == bus_if.in_fu_dst_rob_index) begin
        e.f_rdy = 1; e.f = bus_if.in_fu_nzcv;
      end
    end
    return e;
  endfunction

  function automatic m_ent_t m_new();
    m_ent_t e;
    e.op = bus_if.in_disp_op;
    e.a_rdy = bus_if.in_disp_a_ready;    e.a = bus_if.in_disp_val_a; e.a_tag = bus_if.in_disp_a_rob_index;
    e.b_rdy = bus_if.in_disp_b_ready;    e.b = bus_if.in_disp_val_b; e.b_tag = bus_if.in_disp_b_rob_index;
    e.f_rdy = bus_if.in_disp_nzcv_ready; e.f = bus_if.in_disp_nzcv;  e.f_tag = bus_if.in_disp_nzcv_rob_index;
    e.setf = bus_if.in_disp_set_nzcv;
    e.dst = bus_if.in_disp_dst_rob_index;
    return e;
  endfunction

  // Position of the op the ALU should receive this cycle, or -1.
  function automatic int m_pick();
    if (!bus_if.in_alu_ready || bus_if.in_flush) return -1;
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].a_rdy && mq[i].b_rdy && mq[i].f_rdy) return i;
    return -1;
  endfunction

  task automatic model_compare(input string tag);
    int k;
    logic [191:0] exp, act;
    k = m_pick();
    exp = '0;
    if (k >= 0) exp = {1'b1, mq[k].op, mq[k].a, mq[k].b, mq[k].dst, mq[k].setf, mq[k].f};
    act = {bus_if.out_alu_start, bus_if.out_alu_op, bus_if.out_alu_val_a, bus_if.out_alu_val_b,
           bus_if.out_alu_dst_rob_index, bus_if.out_alu_set_nzcv, bus_if.out_alu_nzcv};
    check({tag, "_issue"}, act, exp);
    check({tag, "_disp_ready"}, bus_if.out_disp_ready, mq.size() < RS_SIZE);
  endtask

  task automatic model_update();
    int k;
    bit acc;
    k   = m_pick();
    acc = bus_if.in_disp_valid && (mq.size() < RS_SIZE);
    if (bus_if.in_flush) begin
      mq.delete();
    end else begin
      if (k >= 0) mq.delete(k);
      for (int i = 0; i < mq.size(); i++) mq[i] = m_wake(mq[i]);
      if (acc) mq.push_back(m_wake(m_new()));
    end
  endtask

  // Compare at the falling edge, advance model at the rising edge.
  task automatic cycle(input string tag);
    @(negedge in_clk);
    model_compare(tag);
    @(posedge in_clk);
    model_update();
    #1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle(input bit alu_rdy);
    bus_if.in_flush = 0;
    bus_if.in_disp_valid = 0; bus_if.in_disp_op = '0;
    bus_if.in_disp_a_ready = 0; bus_if.in_disp_val_a = '0; bus_if.in_disp_a_rob_index = '0;
    bus_if.in_disp_b_ready = 0; bus_if.in_disp_val_b = '0; bus_if.in_disp_b_rob_index = '0;
    bus_if.in_disp_nzcv_ready = 0; bus_if.in_disp_nzcv = '0; bus_if.in_disp_nzcv_rob_index = '0;
    bus_if.in_disp_set_nzcv = 0; bus_if.in_disp_dst_rob_index = '0;
    bus_if.in_fu_done = 0; bus_if.in_fu_dst_rob_index = '0; bus_if.in_fu_value = '0;
    bus_if.in_fu_set_nzcv = 0; bus_if.in_fu_nzcv = '0;
    bus_if.in_alu_ready = alu_rdy;
  endtask

  task automatic disp(input logic [3:0] op,
                      input bit ar, input logic [63:0] a, input logic [4:0] at,
                      input bit br, input logic [63:0] b, input logic [4:0] bt,
                      input bit fr, input logic [3:0] f, input logic [4:0] ft,
                      input bit setf, input logic [4:0] dst);
    bus_if.in_disp_valid = 1; bus_if.in_disp_op = op;
    bus_if.in_disp_a_ready = ar; bus_if.in_disp_val_a = a; bus_if.in_disp_a_rob_index = at;
    bus_if.in_disp_b_ready = br; bus_if.in_disp_val_b = b; bus_if.in_disp_b_rob_index = bt;
    bus_if.in_disp_nzcv_ready = fr; bus_if.in_disp_nzcv = f; bus_if.in_disp_nzcv_rob_index = ft;
    bus_if.in_disp_set_nzcv = setf; bus_if.in_disp_dst_rob_index = dst;
  endtask

  task automatic bcast(input logic [4:0] tag, input logic [63:0] v, input bit setf, input logic [3:0] f);
    bus_if.in_fu_done = 1; bus_if.in_fu_dst_rob_index = tag; bus_if.in_fu_value = v;
    bus_if.in_fu_set_nzcv = setf; bus_if.in_fu_nzcv = f;
  endtask

  // Reset asserted with whatever inputs are currently applied.
  task automatic apply_reset(input string tag);
    in_rst_n = 1'b0;
    mq.delete();
    #1;
    check({tag, "_rst_start"}, bus_if.out_alu_start, 1'b0);
    check({tag, "_rst_disp_ready"}, bus_if.out_disp_ready, 1'b1);
    check({tag, "_rst_data"}, {bus_if.out_alu_op, bus_if.out_alu_val_a, bus_if.out_alu_val_b,
          bus_if.out_alu_dst_rob_index, bus_if.out_alu_set_nzcv, bus_if.out_alu_nzcv}, '0);
    idle(1'b0);
    @(negedge in_clk); @(negedge in_clk);
    in_rst_n = 1'b1;
    @(posedge in_clk); #1;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    bit dv; logic [3:0] op; logic [63:0] a; bit br; logic [63:0] b; logic [4:0] bt; logic [4:0] dst;
    bit fd; logic [4:0] ft; logic [63:0] fv;
    bit e_start; logic [63:0] e_a; logic [63:0] e_b; logic [4:0] e_dst; bit e_drdy;
  } vec_t;

  vec_t tv[11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //        dv op       a     br b     bt    dst   fd ft    fv        st  ea    eb     ed    drdy
    tv[0]  = '{1, OP_PLUS, 64'd5, 1, 64'd7, 5'd0, 5'd3, 0, 5'd0, 64'h0,  0, 64'd0, 64'd0,  5'd0, 1};
    tv[1]  = '{0, 4'd0,    64'd0, 0, 64'd0, 5'd0, 5'd0, 0, 5'd0, 64'h0,  1, 64'd5, 64'd7,  5'd3, 1};
    tv[2]  = '{0, 4'd0,    64'd0, 0, 64'd0, 5'd0, 5'd0, 0, 5'd0, 64'h0,  0, 64'd0, 64'd0,  5'd0, 1};
    tv[3]  = '{1, OP_PLUS, 64'd1, 0, 64'd0, 5'd9, 5'd6, 0, 5'd0, 64'h0,  0, 64'd0, 64'd0,  5'd0, 1};
    tv[4]  = '{0, 4'd0,    64'd0, 0, 64'd0, 5'd0, 5'd0, 0, 5'd0, 64'h0,  0, 64'd0, 64'd0,  5'd0, 1};
    tv[5]  = '{0, 4'd0,    64'd0, 0, 64'd0, 5'd0, 5'd0, 1, 5'd9, 64'h20, 0, 64'd0, 64'd0,  5'd0, 1};
    tv[6]  = '{0, 4'd0,    64'd0, 0, 64'd0, 5'd0, 5'd0, 0, 5'd0, 64'h0,  1, 64'd1, 64'h20, 5'd6, 1};
    tv[7]  = '{0, 4'd0,    64'd0, 0, 64'd0, 5'd0, 5'd0, 0, 5'd0, 64'h0,  0, 64'd0, 64'd0,  5'd0, 1};
    tv[8]  = '{1, OP_PLUS, 64'd2, 0, 64'd0, 5'd7, 5'd2, 1, 5'd7, 64'h99, 0, 64'd0, 64'd0,  5'd0, 1};
    tv[9]  = '{0, 4'd0,    64'd0, 0, 64'd0, 5'd0, 5'd0, 0, 5'd0, 64'h0,  1, 64'd2, 64'h99, 5'd2, 1};
    tv[10] = '{0, 4'd0,    64'd0, 0, 64'd0, 5'd0, 5'd0, 0, 5'd0, 64'h0,  0, 64'd0, 64'd0,  5'd0, 1};

    idle(1'b1);
    apply_reset("por");

    // Table: basic issue, wakeup latency, dispatch-cycle bypass.
    for (int r = 0; r < 11; r++) begin
      idle(1'b1);
      if (tv[r].dv) disp(tv[r].op, 1, tv[r].a, 5'd0, tv[r].br, tv[r].b, tv[r].bt, 1, 4'd0, 5'd0, 0, tv[r].dst);
      if (tv[r].fd) bcast(tv[r].ft, tv[r].fv, 0, 4'd0);
      #2;
      check($sformatf("vec%0d_start", r), bus_if.out_alu_start, tv[r].e_start);
      check($sformatf("vec%0d_val_a", r), bus_if.out_alu_val_a, tv[r].e_a);
      check($sformatf("vec%0d_val_b", r), bus_if.out_alu_val_b, tv[r].e_b);
      check($sformatf("vec%0d_dst", r), bus_if.out_alu_dst_rob_index, tv[r].e_dst);
      check($sformatf("vec%0d_disp_ready", r), bus_if.out_disp_ready, tv[r].e_drdy);
      cycle("vec");
    end

    // Full queue: 5th dispatch dropped; waking entry 2 issues it out of order.
    for (int k = 0; k < 4; k++) begin
      idle(1'b1);
      disp(OP_PLUS, 1, 64'(k), 5'd0, 0, 64'd0, 5'(10 + k), 1, 4'd0, 5'd0, 0, 5'(16 + k));
      cycle("fill");
    end
    idle(1'b1);
    disp(OP_PLUS, 1, 64'd9, 5'd0, 0, 64'd0, 5'd14, 1, 4'd0, 5'd0, 0, 5'd20);
    #2; check("full_disp_ready", bus_if.out_disp_ready, 1'b0);
    cycle("full");
    idle(1'b1); bcast(5'd12, 64'h55, 0, 4'd0);
    #2; check("full_wake_same_cycle", bus_if.out_alu_start, 1'b0);
    cycle("full");
    idle(1'b1);
    #2;
    check("full_issue_e2", {bus_if.out_alu_start, bus_if.out_alu_val_a, bus_if.out_alu_val_b,
          bus_if.out_alu_dst_rob_index}, {1'b1, 64'd2, 64'h55, 5'd18});
    check("full_still_full", bus_if.out_disp_ready, 1'b0);
    cycle("full");
    idle(1'b1);
    #2; check("full_freed", bus_if.out_disp_ready, 1'b1);
    cycle("full");
    idle(1'b1); bcast(5'd14, 64'h77, 0, 4'd0);
    cycle("full");
    idle(1'b1);
    #2; check("full_dropped_absent", bus_if.out_alu_start, 1'b0);
    cycle("full");
    idle(1'b0); bus_if.in_flush = 1;
    cycle("full");

    // Two ready entries with the ALU stalled for 3 cycles, then in order.
    idle(1'b0); disp(OP_PLUS, 1, 64'd11, 5'd0, 1, 64'd12, 5'd0, 1, 4'd0, 5'd0, 0, 5'd1);
    cycle("order");
    idle(1'b0); disp(OP_PLUS, 1, 64'd21, 5'd0, 1, 64'd22, 5'd0, 1, 4'd0, 5'd0, 1, 5'd2);
    cycle("order");
    for (int k = 0; k < 3; k++) begin
      idle(1'b0);
      #2; check("stall_no_issue", bus_if.out_alu_start, 1'b0);
      cycle("stall");
    end
    idle(1'b1);
    #2; check("order_first", {bus_if.out_alu_start, bus_if.out_alu_dst_rob_index, bus_if.out_alu_val_a},
              {1'b1, 5'd1, 64'd11});
    cycle("order");
    idle(1'b1);
    #2; check("order_second", {bus_if.out_alu_start, bus_if.out_alu_dst_rob_index, bus_if.out_alu_set_nzcv},
              {1'b1, 5'd2, 1'b1});
    cycle("order");

    // CSEL waiting on flags: only a flag-carrying broadcast wakes it.
    idle(1'b1); disp(OP_CSEL, 1, 64'd3, 5'd0, 1, 64'd8, 5'd0, 0, 4'd0, 5'd4, 0, 5'd8);
    cycle("csel");
    idle(1'b1); bcast(5'd4, 64'hAB, 0, 4'b1111);
    cycle("csel");
    idle(1'b1); bcast(5'd4, 64'hCD, 1, 4'b0100);
    #2; check("csel_no_wake", bus_if.out_alu_start, 1'b0);
    cycle("csel");
    idle(1'b1);
    #2; check("csel_wake", {bus_if.out_alu_start, bus_if.out_alu_op, bus_if.out_alu_nzcv, bus_if.out_alu_val_b},
              {1'b1, OP_CSEL, 4'b0100, 64'd8});
    cycle("csel");

    // Flush with three entries (one ready) and a simultaneous dispatch.
    idle(1'b0); disp(OP_PLUS, 1, 64'd1, 5'd0, 1, 64'd1, 5'd0, 1, 4'd0, 5'd0, 0, 5'd10);
    cycle("flush");
    for (int k = 0; k < 2; k++) begin
      idle(1'b0); disp(OP_PLUS, 1, 64'd1, 5'd0, 0, 64'd0, 5'(20 + k), 1, 4'd0, 5'd0, 0, 5'(11 + k));
      cycle("flush");
    end
    idle(1'b1); bus_if.in_flush = 1;
    disp(OP_PLUS, 1, 64'd6, 5'd0, 1, 64'd6, 5'd0, 1, 4'd0, 5'd0, 0, 5'd13);
    #2; check("flush_blocks_issue", bus_if.out_alu_start, 1'b0);
    cycle("flush");
    for (int k = 0; k < 2; k++) begin
      idle(1'b1);
      #2; check("flush_empty", {bus_if.out_alu_start, bus_if.out_disp_ready}, {1'b0, 1'b1});
      cycle("flush");
    end

    // Asynchronous reset in the middle of traffic.
    idle(1'b0); disp(OP_PLUS, 1, 64'd4, 5'd0, 1, 64'd4, 5'd0, 1, 4'd0, 5'd0, 0, 5'd14);
    cycle("mid_rst");
    idle(1'b1);
    #2; check("mid_rst_before", bus_if.out_alu_start, 1'b1);
    apply_reset("mid");
    idle(1'b1);
    cycle("mid_rst");

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      idle($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) < 55)
        disp(4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), {$urandom, $urandom}, 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), {$urandom, $urandom}, 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 99) < 50)
        bcast(5'($urandom_range(0, 7)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)));
      bus_if.in_flush = ($urandom_range(0, 59) == 0);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
